lpc_cycle_decoder: RTL and testbench
====================================

# lpc_cycle_decoder

Passive LPC bus decoder, the parametrised successor of the I/O-read sniffer core. Observes `lpc_ad`/`lpc_frame` and reconstructs complete I/O and memory read/write cycles, including sync wait states. Detects host aborts, sync errors and wait timeouts. Emits one registered record per finished or terminated cycle toward the capture/UART path.

## Interface
- `ENABLE_IO`, 1, decode I/O cycles (type 00); 0 means ignore them.
- `ENABLE_MEM`, 1, decode memory cycles (type 01); 0 means ignore them.
- `WAIT_W`, 8, width of the wait-state counter and of `out_wait_count`.
- `MAX_WAIT`, 200, largest number of wait syncs (0101/0110) accepted before timeout; must be < 2^WAIT_W.
- `lpc_clock`  in  1  LPC clock; all logic samples on the rising edge.
- `lpc_reset`  in  1  reset; asynchronous and active-high.
- `lpc_ad`  in  4  LPC address/data nibble bus.
- `lpc_frame`  in  1  LPC frame, active-low.
- `out_cyctype_dir`  out  4  cycle-type/direction nibble as sampled: [3:2] type, [1] 1=write.
- `out_addr`  out  32  cycle address; I/O cycles zero-extended from 16 bits.
- `out_data`  out  8  data byte.
- `out_status`  out  2  00 ok, 01 sync error, 10 abort, 11 timeout/protocol.
- `out_wait_count`  out  WAIT_W  number of wait syncs seen in this cycle.
- `out_clock_enable`  out  1  one-cycle record strobe.

## Operation
- States: IDLE, CTDIR, ADDR, WDATA, TAR_A, SYNC, RDATA, TAR_B.
- Start detection works from any state. A sample with `lpc_frame`=0 and `lpc_ad`=0000 moves to CTDIR. `lpc_frame`=0 with any other value moves to IDLE. A frame held low for several clocks is decided by its last low sample.
- Start clears the address, data and wait-count working registers to 0.
- CTDIR (first sample with `lpc_frame`=1): latch the nibble. Type 00 with ENABLE_IO goes to ADDR with 4 nibbles. Type 01 with ENABLE_MEM goes to ADDR with 8 nibbles. DMA, reserved or disabled types go to IDLE with no record.
- ADDR: shift nibbles in, most significant first. After the last nibble, a write goes to WDATA and a read goes to TAR_A.
- WDATA: 2 nibbles, low nibble first, then TAR_A.
- TAR_A: 2 clocks, `lpc_ad` ignored (may be Z), then SYNC.
- SYNC decoding:
  - 0000 or 1001: ready.
  - 0101 or 0110: wait; increment the wait counter and stay in SYNC.
  - 1010: ready, and mark status 01.
  - Any other value: terminate with status 11.
- Leaving SYNC on ready: a read goes to RDATA (2 nibbles, low first) then TAR_B. A write goes directly to TAR_B.
- TAR_B: 2 clocks. The edge sampling the second TAR_B nibble loads the output registers and returns to IDLE.
- Abort: `lpc_frame`=0 sampled in any state except IDLE/CTDIR terminates the cycle with status 10. That same sample is also evaluated as a start.
- Timeout: a wait sync that would push the counter past MAX_WAIT terminates with status 11. The counter saturates and never wraps.
- Terminated cycles (status 10/11) still emit a record. Fields not yet received read 0.

## Timing
- Reset values: all outputs 0; state IDLE.
- Outputs are registered and held until the next record. `out_clock_enable` is high for exactly the one cycle after the loading edge.
- Minimum length, start edge to loading edge inclusive:
  - I/O read or write: 13 clocks.
  - Memory read or write: 17 clocks.
  - Each wait sync adds 1 clock.
- Abort record: loaded on the edge sampling `lpc_frame`=0.
- Timeout record: loaded on the edge sampling wait sync number MAX_WAIT+1.
- Back-to-back cycles: a start on the clock right after TAR_B is accepted, with no idle clock required.
- Reset mid-cycle: immediate return to IDLE, outputs cleared, no record.

## Test plan
- I/O read 0x7FE5: no waits, data 0x6C. Required: one strobe with addr 0x00007FE5, data 0x6C, ct_dir 0x0, status 00, wait 0, 13 clocks after start.
- Memory write 0xFFFF0010: data 0xA5. Required: addr 0xFFFF0010, data 0xA5, ct_dir 0x6, status 00.
- I/O read with 3× sync 0110, then 0000, data 0x12. Required: wait 3, status 00, strobe 3 clocks later than the no-wait case.
- MAX_WAIT=4 with 5 waits. Required: status 11, wait 4, data 0x00; a following start decodes normally.
- `lpc_frame` low with AD=1111 during ADDR of a memory read. Required: status 10 with partial address. With AD=0000 instead: abort record, then the new cycle decodes fully.
- Cycle type 1000 (DMA), or type 01 with ENABLE_MEM=0. Required: no strobe. Separately, `lpc_reset` pulsed during SYNC: outputs 0 and no strobe.

Source files
------------

// File: rtl/lpc_cycle_decoder.sv
// rtl/lpc_cycle_decoder.sv - passive LPC I/O and memory cycle decoder with wait, abort and timeout handling
//
// Ports:
//   lpc_clock         LPC clock; everything samples on the rising edge
//   lpc_reset         asynchronous active-high reset
//   lpc_ad[3:0]       LPC address/data nibble bus (observed only)
//   lpc_frame         LPC frame, active-low (observed only)
//   out_cyctype_dir   cycle-type/direction nibble as sampled
//   out_addr          cycle address (I/O addresses zero-extended from 16 bits)
//   out_data          data byte
//   out_status        00 ok, 01 sync error, 10 abort, 11 timeout/protocol
//   out_wait_count    wait syncs seen during the recorded cycle
//   out_clock_enable  one-cycle strobe marking a freshly loaded record
module lpc_cycle_decoder #(
    parameter bit ENABLE_IO  = 1'b1,
    parameter bit ENABLE_MEM = 1'b1,
    parameter int WAIT_W     = 8,
    parameter int MAX_WAIT   = 200
) (
    input  logic              lpc_clock,
    input  logic              lpc_reset,
    input  logic [3:0]        lpc_ad,
    input  logic              lpc_frame,
    output logic [3:0]        out_cyctype_dir,
    output logic [31:0]       out_addr,
    output logic [7:0]        out_data,
    output logic [1:0]        out_status,
    output logic [WAIT_W-1:0] out_wait_count,
    output logic              out_clock_enable
);

    typedef enum logic [2:0] {
        IDLE, CTDIR, ADDR, WDATA, TAR_A, SYNC, RDATA, TAR_B
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    state_t            state, state_n;
    logic [3:0]        ct, ct_n;
    logic [31:0]       addr, addr_n;
    logic [7:0]        data, data_n;
    logic [WAIT_W-1:0] wcnt, wcnt_n;
    logic [1:0]        st, st_n;
    // nibbles remaining in the current phase, minus one
    logic [2:0]        cnt, cnt_n;
    logic              load;
    logic [1:0]        load_status;

    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state            <= IDLE;
            ct               <= '0;
            addr             <= '0;
            data             <= '0;
            wcnt             <= '0;
            st               <= '0;
            cnt              <= '0;
            out_cyctype_dir  <= '0;
            out_addr         <= '0;
            out_data         <= '0;
            out_status       <= '0;
            out_wait_count   <= '0;
            out_clock_enable <= 1'b0;
        end else begin
            state            <= state_n;
            ct               <= ct_n;
            addr             <= addr_n;
            data             <= data_n;
            wcnt             <= wcnt_n;
            st               <= st_n;
            cnt              <= cnt_n;
            out_clock_enable <= load;
            if (load) begin
                out_cyctype_dir <= ct;
                out_addr        <= addr;
                out_data        <= data;
                out_status      <= load_status;
                out_wait_count  <= wcnt;
            end
        end
    end

    always_comb begin
        state_n     = state;
        ct_n        = ct;
        addr_n      = addr;
        data_n      = data;
        wcnt_n      = wcnt;
        st_n        = st;
        cnt_n       = cnt;
        load        = 1'b0;
        load_status = st;

        if (!lpc_frame) begin
            // A low frame mid-cycle records the partial cycle as aborted and is
            // then judged as a start like any other low-frame sample.
            if (state != IDLE && state != CTDIR) begin
                load        = 1'b1;
                load_status = 2'b10;
            end
            if (lpc_ad == 4'b0000) begin
                state_n = CTDIR;
                ct_n    = '0;
                addr_n  = '0;
                data_n  = '0;
                wcnt_n  = '0;
                st_n    = '0;
            end else begin
                state_n = IDLE;
            end
        end else begin
            case (state)
                IDLE: ;
                CTDIR: begin
                    ct_n = lpc_ad;
                    if (lpc_ad[3:2] == 2'b00 && ENABLE_IO) begin
                        state_n = ADDR;
                        cnt_n   = 3'd3;
                    end else if (lpc_ad[3:2] == 2'b01 && ENABLE_MEM) begin
                        state_n = ADDR;
                        cnt_n   = 3'd7;
                    end else begin
                        state_n = IDLE;
                    end
                end
                ADDR: begin
                    // nibbles land in their final position so an abort leaves
                    // unreceived nibbles at zero
                    addr_n[{cnt, 2'b00} +: 4] = lpc_ad;
                    if (cnt == 3'd0) begin
                        state_n = ct[1] ? WDATA : TAR_A;
                        cnt_n   = 3'd1;
                    end else begin
                        cnt_n = cnt - 3'd1;
                    end
                end
                WDATA, RDATA: begin
                    data_n[{~cnt[0], 2'b00} +: 4] = lpc_ad;
                    if (cnt[0]) begin
                        cnt_n = 3'd0;
                    end else begin
                        state_n = (state == WDATA) ? TAR_A : TAR_B;
                        cnt_n   = 3'd1;
                    end
                end
                TAR_A: begin
                    if (cnt[0]) cnt_n = 3'd0;
                    else        state_n = SYNC;
                end
                SYNC: begin
                    case (lpc_ad)
                        4'b0000, 4'b1001, 4'b1010: begin
                            if (lpc_ad == 4'b1010) st_n = 2'b01;
                            state_n = ct[1] ? TAR_B : RDATA;
                            cnt_n   = 3'd1;
                        end
                        4'b0101, 4'b0110: begin
                            if (wcnt == MAX_W) begin
                                load        = 1'b1;
                                load_status = 2'b11;
                                state_n     = IDLE;
                            end else begin
                                wcnt_n = wcnt + 1'b1;
                            end
                        end
                        default: begin
                            load        = 1'b1;
                            load_status = 2'b11;
                            state_n     = IDLE;
                        end
                    endcase
                end
                TAR_B: begin
                    if (cnt[0]) begin
                        cnt_n = 3'd0;
                    end else begin
                        load    = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// tb/tb_lpc_cycle_decoder.sv - scoreboard bench for lpc_cycle_decoder (full decoder and memory-disabled decoder)
module tb_lpc_cycle_decoder;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       lpc_reset;
    logic [3:0] lpc_ad;
    logic       lpc_frame;

    logic [3:0]  ct_a, ct_b;
    logic [31:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic [1:0]  st_a, st_b;
    logic [7:0]  wc_a, wc_b;
    logic        ce_a, ce_b;

    lpc_cycle_decoder #(.ENABLE_IO(1'b1), .ENABLE_MEM(1'b1), .WAIT_W(8), .MAX_WAIT(MAXW)) dut_a (
        .lpc_clock(clk), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
        .out_cyctype_dir(ct_a), .out_addr(addr_a), .out_data(data_a), .out_status(st_a),
        .out_wait_count(wc_a), .out_clock_enable(ce_a));

    lpc_cycle_decoder #(.ENABLE_IO(1'b1), .ENABLE_MEM(1'b0), .WAIT_W(8), .MAX_WAIT(MAXW)) dut_b (
        .lpc_clock(clk), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
        .out_cyctype_dir(ct_b), .out_addr(addr_b), .out_data(data_b), .out_status(st_b),
        .out_wait_count(wc_b), .out_clock_enable(ce_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ct;
        logic [31:0] addr;
        logic [7:0]  data;
        logic [1:0]  st;
        logic [7:0]  wc;
        int          at_edge;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];
    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_edge = 0;
    int   start_edge = 0;

    // state of the cycle currently being generated
    rec_t       g_r;
    int         g_p;
    int         g_abort_at;
    logic [3:0] g_abort_ad;
    bit         g_ea, g_eb, g_done, g_restart;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    rec_t ra, rb;
    always @(negedge clk) begin
        if (ce_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_strobe", 1, 0);
            end else begin
                ra = qa.pop_front();
                check("a_ct", ct_a, ra.ct);
                check("a_addr", addr_a, ra.addr);
                check("a_data", data_a, ra.data);
                check("a_status", st_a, ra.st);
                check("a_wait", wc_a, ra.wc);
                check("a_edge", cyc, ra.at_edge);
            end
        end
        if (ce_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_strobe", 1, 0);
            end else begin
                rb = qb.pop_front();
                check("b_ct", ct_b, rb.ct);
                check("b_addr", addr_b, rb.addr);
                check("b_data", data_b, rb.data);
                check("b_status", st_b, rb.st);
                check("b_wait", wc_b, rb.wc);
                check("b_edge", cyc, rb.at_edge);
            end
        end
    end

    task automatic emit(input logic f, input logic [3:0] a);
        @(negedge clk);
        lpc_frame = f;
        lpc_ad    = a;
        last_edge = cyc + 1;
    endtask

    task automatic push_rec(input logic [1:0] st);
        rec_t r;
        r = g_r;
        r.st = st;
        r.at_edge = last_edge;
        if (g_ea) qa.push_back(r);
        if (g_eb) qb.push_back(r);
    endtask

    // one protocol sample slot; the abort, if scheduled here, replaces it
    task automatic slot(input logic [3:0] a);
        if (g_p == g_abort_at) begin
            emit(1'b0, g_abort_ad);
            if (g_p > 0) push_rec(2'b10);
            g_done    = 1'b1;
            g_restart = (g_abort_ad == 4'b0000);
        end else begin
            emit(1'b1, a);
            g_p++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) emit(1'b1, 4'($urandom_range(0, 15)));
    endtask

    // Reference model: walks the protocol as a host/peripheral would drive it and
    // derives the record each decoder must emit from the cycle rules.
    task automatic gen_cycle(input logic [3:0] ct, input logic [31:0] addr, input logic [7:0] data,
                             input int nwait, input logic [3:0] wnib, input logic [3:0] rnib,
                             input int abort_at, input logic [3:0] abort_ad, input bit skip_start);
        int n;
        logic [3:0] nib;
        g_r = '{default: 0};
        g_p = 0;
        g_done = 1'b0;
        g_restart = 1'b0;
        g_abort_at = abort_at;
        g_abort_ad = abort_ad;
        g_ea = (ct[3:2] == 2'b00) || (ct[3:2] == 2'b01);
        g_eb = (ct[3:2] == 2'b00);
        n = (ct[3:2] == 2'b01) ? 8 : 4;
        if (!skip_start) begin
            emit(1'b0, 4'b0000);
            start_edge = last_edge;
        end
        slot(ct); if (g_done) return;
        g_r.ct = ct;
        if (!g_ea) return;
        for (int i = 0; i < n; i++) begin
            nib = addr[4*(n-1-i) +: 4];
            slot(nib); if (g_done) return;
            g_r.addr[4*(n-1-i) +: 4] = nib;
        end
        if (ct[1]) begin
            for (int i = 0; i < 2; i++) begin
                slot(data[4*i +: 4]); if (g_done) return;
                g_r.data[4*i +: 4] = data[4*i +: 4];
            end
        end
        for (int i = 0; i < 2; i++) begin
            slot(4'($urandom_range(0, 15))); if (g_done) return;
        end
        for (int w = 0; w < nwait; w++) begin
            slot(wnib); if (g_done) return;
            if (int'(g_r.wc) == MAXW) begin
                push_rec(2'b11);
                return;
            end
            g_r.wc = g_r.wc + 8'd1;
        end
        slot(rnib); if (g_done) return;
        if (rnib == 4'b1010) begin
            g_r.st = 2'b01;
        end else if (rnib != 4'b0000 && rnib != 4'b1001) begin
            push_rec(2'b11);
            return;
        end
        if (!ct[1]) begin
            for (int i = 0; i < 2; i++) begin
                slot(data[4*i +: 4]); if (g_done) return;
                g_r.data[4*i +: 4] = data[4*i +: 4];
            end
        end
        slot(4'($urandom_range(0, 15))); if (g_done) return;
        slot(4'($urandom_range(0, 15))); if (g_done) return;
        push_rec(g_r.st);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_outs"}, {ct_a, addr_a, data_a, st_a, wc_a, ce_a}, 0);
        check({tag, "_b_outs"}, {ct_b, addr_b, data_b, st_b, wc_b, ce_b}, 0);
    endtask

    initial begin
        logic [3:0] ct, wn, rn, aad;
        int sel, ab;
        bit rs;

        lpc_reset = 1'b1;
        lpc_frame = 1'b1;
        lpc_ad    = 4'h0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) lpc_reset = 1'b0;
        idle(2);

        gen_cycle(4'h0, 32'h0000_7FE5, 8'h6C, 0, 4'h6, 4'h0, -1, 4'h0, 0);
        check("io_read_len", last_edge - start_edge + 1, 13);
        idle(1);
        gen_cycle(4'h6, 32'hFFFF_0010, 8'hA5, 0, 4'h6, 4'h0, -1, 4'h0, 0);
        check("mem_write_len", last_edge - start_edge + 1, 17);
        gen_cycle(4'h0, 32'h0000_1234, 8'h12, 3, 4'h6, 4'h0, -1, 4'h0, 0);
        check("io_wait3_len", last_edge - start_edge + 1, 16);
        gen_cycle(4'h0, 32'h0000_0080, 8'h77, 5, 4'h5, 4'h0, -1, 4'h0, 0);
        gen_cycle(4'h2, 32'h0000_03F8, 8'h41, 0, 4'h6, 4'h9, -1, 4'h0, 0);
        gen_cycle(4'h4, 32'h1234_5678, 8'h00, 0, 4'h6, 4'h0, 4, 4'hF, 0);
        idle(1);
        gen_cycle(4'h4, 32'h1234_5678, 8'h00, 0, 4'h6, 4'h0, 3, 4'h0, 0);
        check("abort_restart_flag", g_restart, 1);
        gen_cycle(4'h4, 32'h89AB_CDEF, 8'h5A, 1, 4'h5, 4'h0, -1, 4'h0, 1);
        gen_cycle(4'h8, 32'h0000_0000, 8'h00, 0, 4'h6, 4'h0, -1, 4'h0, 0);
        idle(12);

        // reset pulsed while the decoders sit in SYNC
        emit(1'b0, 4'h0); emit(1'b1, 4'h0);
        emit(1'b1, 4'h0); emit(1'b1, 4'h0); emit(1'b1, 4'h6); emit(1'b1, 4'h0);
        emit(1'b1, 4'hF); emit(1'b1, 4'hF); emit(1'b1, 4'h6);
        @(negedge clk);
        lpc_reset = 1'b1;
        lpc_frame = 1'b1;
        @(posedge clk);
        #1 check_zero("midreset");
        @(negedge clk) lpc_reset = 1'b0;
        idle(3);
        #1 check_zero("postreset");

        rs = 1'b0;
        for (int k = 0; k < 70; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       ct = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
            else if (sel < 8)  ct = {2'b01, 1'($urandom_range(0, 1)), 1'b0};
            else               ct = {1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            wn = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'h6;
            sel = $urandom_range(0, 9);
            rn = (sel < 5) ? 4'h0 : (sel < 7) ? 4'h9 : (sel < 9) ? 4'hA : 4'h3;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
            aad = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (!rs) idle($urandom_range(0, 2));
            gen_cycle(ct, $urandom, 8'($urandom), $urandom_range(0, 5), wn, rn, ab, aad, rs);
            rs = g_restart;
        end
        if (rs) emit(1'b1, 4'h0);
        idle(6);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
